// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// Ties go to data, or round-robin against the last grant when MEM_ARB_RR_EN is defined.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic dm_req_i,
`ifdef MEM_ARB_RR_EN
  input  gnt_e last_gnt_i,
`endif
  output logic gnt_vld_o,
  output gnt_e gnt_id_o
);

  always_comb begin
    gnt_vld_o = if_req_i | dm_req_i;
    gnt_id_o  = GNT_IF;
    if (if_req_i && dm_req_i) begin
`ifdef MEM_ARB_RR_EN
      gnt_id_o = (last_gnt_i == GNT_DM) ? GNT_IF : GNT_DM;
`else
      gnt_id_o = GNT_DM;
`endif
    end else if (dm_req_i) begin
      gnt_id_o = GNT_DM;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between fetch and load/store ports with a fixed-latency access.
// Optional round-robin tie-breaking is enabled with the MEM_ARB_RR_EN macro.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              stall_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

  state_e            state_q;
  logic [1:0]        cnt_q;
  gnt_e              gnt_q;
  logic              mem_ce_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_ack_q, dm_ack_q;

  logic              gnt_vld;
  gnt_e              gnt_id;
  logic              req_we_d;
  logic [ADDR_W-1:0] req_addr_d;
  logic [DATA_W-1:0] req_wdata_d;

`ifdef MEM_ARB_RR_EN
  gnt_e last_gnt_q;
`endif

  mem_arb_pick u_pick (
    .if_req_i   (if_req_i),
    .dm_req_i   (dm_req_i),
`ifdef MEM_ARB_RR_EN
    .last_gnt_i (last_gnt_q),
`endif
    .gnt_vld_o  (gnt_vld),
    .gnt_id_o   (gnt_id)
  );

  // Fetches never write; only the data port supplies we and wdata.
  always_comb begin
    req_we_d    = 1'b0;
    req_addr_d  = if_addr_i;
    req_wdata_d = mem_wdata_q;
    if (gnt_id == GNT_DM) begin
      req_we_d    = dm_we_i;
      req_addr_d  = dm_addr_i;
      req_wdata_d = dm_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      gnt_q       <= GNT_IF;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_gnt_q  <= GNT_DM;
`endif
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            gnt_q       <= gnt_id;
            mem_ce_q    <= 1'b1;
            mem_we_q    <= req_we_d;
            mem_addr_q  <= req_addr_d;
            mem_wdata_q <= req_wdata_d;
            cnt_q       <= 2'd0;
            state_q     <= ACCESS;
`ifdef MEM_ARB_RR_EN
            last_gnt_q  <= gnt_id;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            mem_ce_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (!mem_we_q) begin
              if (gnt_q == GNT_DM) dm_rdata_q <= mem_rdata_i;
              else                 if_rdata_q <= mem_rdata_i;
            end
            if (gnt_q == GNT_DM) dm_ack_q <= 1'b1;
            else                 if_ack_q <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign stall_o     = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter at MEM_LAT=2; expectations follow MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk, rst;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack, stall;
  logic        mem_ce, mem_we;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  exp_t        sb[$];
  int          cyc;
  int          n_tests, n_fail;
  logic [31:0] exp_dm;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_rdata_o (if_rdata),
    .if_ack_o   (if_ack),
    .dm_req_i   (dm_req),
    .dm_we_i    (dm_we),
    .dm_addr_i  (dm_addr),
    .dm_wdata_i (dm_wdata),
    .dm_rdata_o (dm_rdata),
    .dm_ack_o   (dm_ack),
    .stall_o    (stall),
    .mem_ce_o   (mem_ce),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h4) return 32'h0050_0093;
    return (a * 32'd3) + 32'h1234_0000;
  endfunction

  assign mem_rdata = rd_model(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Each ack pops the oldest expectation and checks port, data and cycle.
  always @(negedge clk) begin
    if (!rst && (if_ack || dm_ack)) begin
      if (if_ack && dm_ack) begin
        chk("dual_ack", 32'd1, 32'd0);
      end else if (sb.size() == 0) begin
        chk("unexp_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_port", 32'(dm_ack), 32'(e.port));
        chk("ack_data", dm_ack ? dm_rdata : if_rdata, e.data);
        chk("ack_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step_drop(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (if_ack) if_req = 1'b0;
      if (dm_ack) dm_req = 1'b0;
    end
  endtask

`ifdef MEM_ARB_RR_EN
  localparam int IF_A1 = 3, IF_A2 = 11, DM_A = 7, IF_DROP_N = 2;
`else
  localparam int IF_A1 = 7, IF_A2 = -1, DM_A = 3, IF_DROP_N = 1;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n_if_acks;
    logic exp_if_a, exp_dm_a;
    n_tests = 0; n_fail = 0; cyc = 0; exp_dm = '0;
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (2) tick();
    chk("rst_ce", 32'(mem_ce), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_ack", 32'(if_ack | dm_ack), 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_stall", 32'(stall), 32'd0);

    // Single fetch
    if_addr = 32'h4; if_req = 1'b1; base = cyc;
    sb.push_back('{1'b0, 32'h0050_0093, base + 3});
    #1 chk("sf_stall", 32'(stall), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("sf_ce", 32'(mem_ce), 32'(k < 3));
      if (k < 3) chk("sf_addr", mem_addr, 32'h4);
      if (k == 1) chk("sf_we", 32'(mem_we), 32'd0);
      if (if_ack) if_req = 1'b0;
    end
    step_drop(3);
    chk("sf_pending", 32'(sb.size()), 32'd0);

    // Load
    dm_we = 1'b0; dm_addr = 32'h200; dm_req = 1'b1; base = cyc;
    exp_dm = rd_model(32'h200);
    sb.push_back('{1'b1, exp_dm, base + 3});
    step_drop(5);
    chk("ld_pending", 32'(sb.size()), 32'd0);

    // Store: wdata changes after grant must be ignored; dm_rdata holds
    dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1; base = cyc;
    sb.push_back('{1'b1, exp_dm, base + 3});
    for (int k = 1; k <= 2; k++) begin
      tick();
      dm_wdata = 32'h0; dm_addr = 32'h0;
      chk("st_we", 32'(mem_we), 32'd1);
      chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_addr", mem_addr, 32'h100);
    end
    step_drop(4);
    dm_we = 1'b0;
    chk("st_pending", 32'(sb.size()), 32'd0);

    // Tie
    if_addr = 32'h8; dm_addr = 32'h204; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; base = cyc; n_if_acks = 0;
`ifdef MEM_ARB_RR_EN
    sb.push_back('{1'b0, rd_model(32'h8), base + IF_A1});
    sb.push_back('{1'b1, rd_model(32'h204), base + DM_A});
    sb.push_back('{1'b0, rd_model(32'h8), base + IF_A2});
`else
    sb.push_back('{1'b1, rd_model(32'h204), base + DM_A});
    sb.push_back('{1'b0, rd_model(32'h8), base + IF_A1});
`endif
    exp_dm = rd_model(32'h204);
    for (int k = 0; k < 14; k++) begin
      #1;
      exp_if_a = (k == IF_A1) || (k == IF_A2);
      exp_dm_a = (k == DM_A);
      chk("tie_stall", 32'(stall), 32'((if_req & ~exp_if_a) | (dm_req & ~exp_dm_a)));
      if (if_ack) begin
        n_if_acks++;
        if (n_if_acks == IF_DROP_N) if_req = 1'b0;
      end
      if (dm_ack) dm_req = 1'b0;
      tick();
    end
    chk("tie_pending", 32'(sb.size()), 32'd0);

    // Reset in ACCESS cycle 1, request held through reset
    if_addr = 32'hC; if_req = 1'b1;
    tick();
    chk("rm_ce_pre", 32'(mem_ce), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rm_ce", 32'(mem_ce), 32'd0);
    chk("rm_addr", mem_addr, 32'd0);
    chk("rm_rdata", if_rdata | dm_rdata, 32'd0);
    exp_dm = '0;
    repeat (3) tick();
    rst = 1'b0; base = cyc;
    sb.push_back('{1'b0, rd_model(32'hC), base + 3});
    step_drop(6);
    chk("rm_pending", 32'(sb.size()), 32'd0);
    chk("rm_dm_hold", dm_rdata, exp_dm);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified memory between the core's instruction-fetch port and its load/store port. Each requester holds a level request; the arbiter grants one, runs a fixed-latency memory access, and returns a one-cycle acknowledge with read data. A combined stall output lets the core freeze its PC and datapath while any access is outstanding. The block sits between the `riscv` core's memory ports and the memory model.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, memory cycles per access; legal values are 1..4
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high (high is reset)
- `if_req_i`  in  1  fetch request, held until `if_ack_o`
- `if_addr_i`  in  ADDR_W  fetch address
- `if_rdata_o`  out  DATA_W  fetched instruction; valid with `if_ack_o`
- `if_ack_o`  out  1  one-cycle completion pulse
- `dm_req_i`  in  1  data request, held until `dm_ack_o`
- `dm_we_i`  in  1  1 = store, 0 = load
- `dm_addr_i`  in  ADDR_W  data address
- `dm_wdata_i`  in  DATA_W  store data
- `dm_rdata_o`  out  DATA_W  load data; valid with `dm_ack_o`
- `dm_ack_o`  out  1  one-cycle completion pulse
- `stall_o`  out  1  core stall
- `mem_ce_o`  out  1  memory enable
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_wdata_o`  out  DATA_W  memory write data
- `mem_rdata_i`  in  DATA_W  memory read data

## Operation
- **States:**
  - IDLE: no access in progress.
  - ACCESS: drives the memory; a counter runs 0..MEM_LAT-1.
  - RESP: acknowledges the completed access.
- **IDLE:**
  - If any request is high, pick a winner and latch its addr/we/wdata into the `mem_*` output registers and the grant flag.
  - Go to ACCESS with the counter at 0.
  - With no request, stay in IDLE.
- **ACCESS:**
  - `mem_ce_o`=1, with `mem_we_o` set from the latched we (always 0 for fetch).
  - At the edge where the counter equals MEM_LAT-1, capture `mem_rdata_i` into the granted port's rdata register (reads only), then go to RESP.
- **RESP:**
  - `mem_ce_o`=`mem_we_o`=0.
  - Pulse the granted port's ack for exactly one cycle.
  - Go to IDLE unconditionally.
- **Latching and request timing:**
  - Address and data are sampled only in the grant cycle; later changes are ignored.
  - A request dropped after grant still completes and acks.
- **Stores:** `dm_rdata_o` keeps its previous value.
- **rdata hold:** each rdata register holds its value until the next read on that port.
- **Stall:** `stall_o` = (`if_req_i` & ~`if_ack_o`) | (`dm_req_i` & ~`dm_ack_o`). It is combinational and is the only non-registered output.
- **Default priority:** on a tie in IDLE, the data port wins.

## Timing
- **Reset values:** every registered output is 0, the state is IDLE, the counter is 0, and the round-robin pointer is DATA.
- **Latency:** request seen in IDLE at cycle 0 → ACCESS in cycles 1..MEM_LAT → ack in cycle MEM_LAT+1.
- **Throughput:** at most one transaction per MEM_LAT+2 cycles. RESP never chains directly to ACCESS.
- **Reset mid-access:** the transaction is dropped with no ack and memory outputs go to 0 immediately. A held request is re-granted after reset release.
- **MEM_LAT=1:** ACCESS lasts exactly one cycle.

## Configuration
- **`MEM_ARB_RR_EN` defined:** ties are resolved round-robin. A 1-bit last-grant register is updated on every grant; on a tie, the port not granted last wins. Its reset value is DATA, so the first tie goes to fetch.
- **`MEM_ARB_RR_EN` undefined:** fixed data-port priority and no last-grant register.

## Structure
- Package `mem_arb_pkg` holds:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - grant encoding: GNT_IF=1'b0, GNT_DM=1'b1.
- One combinational sub-module `mem_arb_pick`.
  - Inputs: two requests and the last grant.
  - Outputs: grant valid and grant id.
  - Contains the `MEM_ARB_RR_EN` logic.

## Test plan
All scenarios use MEM_LAT=2.
- **Reset:** assert `rst` mid-run → all outputs 0 asynchronously; no ack follows release.
- **Single fetch:**
  - Stimulus: `if_addr_i`=0x00000004, `mem_rdata_i`=0x00500093.
  - Response: `mem_ce_o`=1, `mem_addr_o`=0x4 in cycles 1–2; `if_ack_o`=1 and `if_rdata_o`=0x00500093 in cycle 3 only.
- **Store:**
  - Stimulus: `dm_we_i`=1, addr 0x100, wdata 0xDEADBEEF.
  - Response: `mem_we_o`=1 in cycles 1–2 with `mem_wdata_o`=0xDEADBEEF; `dm_ack_o` in cycle 3; `dm_rdata_o` unchanged.
- **Tie, macro undefined:** both requests at cycle 0 → `dm_ack_o` in cycle 3 and `if_ack_o` in cycle 7. `stall_o` is high in cycles 0–7 except the cycle-7 drop once fetch is acked.
- **Tie, `MEM_ARB_RR_EN` defined:** `if_ack_o` in cycle 3, then `dm_ack_o` in cycle 7. A second tie grants data first.
- **Reset in ACCESS cycle 1:** `rst`=1 → no ack. Release with `if_req_i` held → re-grant, with `if_ack_o` exactly MEM_LAT+1 cycles after the first IDLE cycle.
